// File: rtl/uart_word_ctrl_if.sv
// Bundle of the byte-side FIFO/UART signals and the word-side client handshake
// seen by uart_word_ctrl. The master modport is the controller's view; the
// slave modport is the view of the datapath/client around it.
interface uart_word_ctrl_if #(
   parameter int NB_DATA = 8,
   parameter int NB_WORD = 32
);
   // RX FIFO (first-word-fall-through)
   logic               i_rx_empty;
   logic [NB_DATA-1:0] i_rdata;
   logic               o_rd;
   // TX FIFO and UART transmitter
   logic               i_tx_full;
   logic               i_tx_empty;
   logic               o_wr;
   logic [NB_DATA-1:0] o_wdata;
   logic               o_tx_start;
   logic               i_tx_done;
   // Word-wide client
   logic [NB_WORD-1:0] o_rx_word;
   logic               o_rx_valid;
   logic               i_rx_ready;
   logic [NB_WORD-1:0] i_tx_word;
   logic               i_tx_valid;
   logic               o_tx_ready;

   modport master (
      input  i_rx_empty, i_rdata, i_tx_full, i_tx_empty, i_tx_done,
             i_rx_ready, i_tx_word, i_tx_valid,
      output o_rd, o_wr, o_wdata, o_tx_start, o_rx_word, o_rx_valid, o_tx_ready
   );

   modport slave (
      output i_rx_empty, i_rdata, i_tx_full, i_tx_empty, i_tx_done,
             i_rx_ready, i_tx_word, i_tx_valid,
      input  o_rd, o_wr, o_wdata, o_tx_start, o_rx_word, o_rx_valid, o_tx_ready
   );
endinterface

// File: rtl/uart_word_ctrl.sv
// Word/byte sequencing controller between a UART byte datapath and a word
// client. Three independent FSMs: RX word assembly with inter-byte timeout,
// TX word splitting into the TX FIFO, and one-start-per-done UART pacing.
module uart_word_ctrl #(
   parameter int NB_DATA    = 8,
   parameter int NB_WORD    = 32,
   parameter int NB_TIMEOUT = 16
) (
   input  logic                  clk,
   input  logic                  i_rst_n,
   uart_word_ctrl_if.master      bus,
   input  logic [NB_TIMEOUT-1:0] i_timeout,
   output logic                  o_rx_timeout,
   output logic                  o_busy
);
   localparam int                NB_BYTES  = NB_WORD / NB_DATA;
   localparam int                NB_CNT    = (NB_BYTES > 1) ? $clog2(NB_BYTES) : 1;
   localparam logic [NB_CNT-1:0] LAST_LANE = NB_CNT'(NB_BYTES - 1);

   localparam logic [0:0] RX_COLLECT = 1'b0;
   localparam logic [0:0] RX_HOLD    = 1'b1;
   localparam logic [0:0] TX_IDLE    = 1'b0;
   localparam logic [0:0] TX_PUSH    = 1'b1;
   localparam logic [0:0] S_IDLE     = 1'b0;
   localparam logic [0:0] S_WAIT     = 1'b1;

   logic                  en_q, en_d;
   logic [0:0]            rx_state_q, rx_state_d;
   logic [NB_CNT-1:0]     rcnt_q, rcnt_d;
   logic [NB_TIMEOUT-1:0] timer_q, timer_d, timer_inc;
   logic [NB_WORD-1:0]    rx_word_q, rx_word_d;
   logic                  rx_timeout_q, rx_timeout_d;
   logic                  rd;
   logic [0:0]            tx_state_q, tx_state_d;
   logic [NB_CNT-1:0]     tcnt_q, tcnt_d;
   logic [NB_WORD-1:0]    tx_word_q, tx_word_d;
   logic                  wr;
   logic [0:0]            st_state_q, st_state_d;
   logic                  tx_start;

   // Enable goes high on the first edge after reset; it keeps the FIFO pop and
   // UART start strobes low while reset is held even if the FIFOs are non-empty.
   always_comb begin
      en_d = 1'b1;
   end

   // RX: pop while collecting, place each byte in its lane, time out partial words.
   always_comb begin
      // NOTE: every variable gets a default first so no path leaves it unassigned
      // (which would infer a latch).
      rx_state_d   = rx_state_q;
      rcnt_d       = rcnt_q;
      timer_d      = timer_q;
      rx_word_d    = rx_word_q;
      rx_timeout_d = 1'b0;
      timer_inc    = timer_q + NB_TIMEOUT'(1);
      rd           = en_q && (rx_state_q == RX_COLLECT) && !bus.i_rx_empty;
      case (rx_state_q)
         RX_COLLECT: begin
            if (rd) begin
               // A pop always wins over a simultaneous timeout.
               rx_word_d[int'(rcnt_q) * NB_DATA +: NB_DATA] = bus.i_rdata;
               timer_d = '0;
               if (rcnt_q == LAST_LANE) begin
                  rcnt_d     = '0;
                  rx_state_d = RX_HOLD;
               end else begin
                  rcnt_d = rcnt_q + NB_CNT'(1);
               end
            end else if (rcnt_q != '0 && i_timeout != '0) begin
               if (timer_inc >= i_timeout) begin
                  rcnt_d       = '0;
                  timer_d      = '0;
                  rx_timeout_d = 1'b1;
               end else begin
                  timer_d = timer_inc;
               end
            end else begin
               timer_d = '0;
            end
         end
         default: begin
            // HOLD: word stays put and no pops until the client takes it.
            timer_d = '0;
            if (bus.i_rx_ready) rx_state_d = RX_COLLECT;
         end
      endcase
   end

   // TX word: latch client word, push lanes LSB first, stall while the FIFO is full.
   always_comb begin
      tx_state_d = tx_state_q;
      tcnt_d     = tcnt_q;
      tx_word_d  = tx_word_q;
      wr         = (tx_state_q == TX_PUSH) && !bus.i_tx_full;
      case (tx_state_q)
         TX_IDLE: begin
            if (bus.i_tx_valid) begin
               tx_word_d  = bus.i_tx_word;
               tcnt_d     = '0;
               tx_state_d = TX_PUSH;
            end
         end
         default: begin
            if (wr) begin
               if (tcnt_q == LAST_LANE) begin
                  tcnt_d     = '0;
                  tx_state_d = TX_IDLE;
               end else begin
                  tcnt_d = tcnt_q + NB_CNT'(1);
               end
            end
         end
      endcase
   end

   // Start sequencer: one start per byte, then wait for the UART's done pulse.
   always_comb begin
      st_state_d = st_state_q;
      tx_start   = en_q && (st_state_q == S_IDLE) && !bus.i_tx_empty;
      case (st_state_q)
         S_IDLE:  if (tx_start) st_state_d = S_WAIT;
         default: if (bus.i_tx_done) st_state_d = S_IDLE;
      endcase
   end

   // State registers for all three paths.
   always_ff @(posedge clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         // NOTE: sequential state uses non-blocking assignments so every flop
         // samples the pre-edge values regardless of process ordering.
         en_q         <= 1'b0;
         rx_state_q   <= RX_COLLECT;
         rcnt_q       <= '0;
         timer_q      <= '0;
         rx_word_q    <= '0;
         rx_timeout_q <= 1'b0;
         tx_state_q   <= TX_IDLE;
         tcnt_q       <= '0;
         tx_word_q    <= '0;
         st_state_q   <= S_IDLE;
      end else begin
         en_q         <= en_d;
         rx_state_q   <= rx_state_d;
         rcnt_q       <= rcnt_d;
         timer_q      <= timer_d;
         rx_word_q    <= rx_word_d;
         rx_timeout_q <= rx_timeout_d;
         tx_state_q   <= tx_state_d;
         tcnt_q       <= tcnt_d;
         tx_word_q    <= tx_word_d;
         st_state_q   <= st_state_d;
      end
   end

   assign bus.o_rd       = rd;
   assign bus.o_rx_word  = rx_word_q;
   assign bus.o_rx_valid = (rx_state_q == RX_HOLD);
   assign bus.o_wr       = wr;
   assign bus.o_wdata    = tx_word_q[int'(tcnt_q) * NB_DATA +: NB_DATA];
   assign bus.o_tx_ready = (tx_state_q == TX_IDLE);
   assign bus.o_tx_start = tx_start;
   assign o_rx_timeout   = rx_timeout_q;
   assign o_busy         = (rx_state_q != RX_COLLECT) || (rcnt_q != '0) ||
                           (tx_state_q != TX_IDLE) || (st_state_q != S_IDLE) ||
                           !bus.i_tx_empty;
endmodule

// File: tb/tb_uart_word_ctrl.sv
// Directed bench for uart_word_ctrl: RX FIFO modelled as a byte queue, TX FIFO
// flags and UART done driven by hand. Inputs change 1 ns after the rising edge,
// outputs are sampled on the falling edge.
module tb_uart_word_ctrl;
   logic        clk;
   logic        rst_n;
   logic [15:0] timeout;
   logic        rx_timeout;
   logic        busy;

   uart_word_ctrl_if #(.NB_DATA(8), .NB_WORD(32)) bus ();

   uart_word_ctrl #(.NB_DATA(8), .NB_WORD(32), .NB_TIMEOUT(16)) dut (
      .clk          (clk),
      .i_rst_n      (rst_n),
      .bus          (bus),
      .i_timeout    (timeout),
      .o_rx_timeout (rx_timeout),
      .o_busy       (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // RX FIFO model and per-cycle monitors
   logic [7:0]  rxq[$];
   logic [7:0]  wlog[$];
   logic        s_rd, s_wr, s_start, s_valid, s_timeout, s_ready, s_busy;
   logic [7:0]  s_wdata;
   logic [31:0] s_word;
   int cyc, pop_cnt, first_pop_cyc, last_pop_cyc, tmo_cnt, tmo_cyc;
   int start_cnt, start_cyc, wr_full_cnt, hold_pop_cnt, bad_ready;
   logic push_window;

   task automatic drive_rx();
      bus.i_rx_empty = (rxq.size() == 0);
      bus.i_rdata    = (rxq.size() == 0) ? 8'h00 : rxq[0];
   endtask

   task automatic load_rx(input logic [31:0] bytes, input int n);
      for (int i = 0; i < n; i++) rxq.push_back(bytes[8*i +: 8]);
      drive_rx();
   endtask

   task automatic tick();
      @(negedge clk);
      cyc++;
      s_rd = bus.o_rd;  s_wr = bus.o_wr;  s_wdata = bus.o_wdata;
      s_start = bus.o_tx_start;  s_valid = bus.o_rx_valid;  s_word = bus.o_rx_word;
      s_ready = bus.o_tx_ready;  s_timeout = rx_timeout;  s_busy = busy;
      if (s_rd) begin
         if (pop_cnt == 0) first_pop_cyc = cyc;
         pop_cnt++;
         last_pop_cyc = cyc;
         if (s_valid) hold_pop_cnt++;
      end
      if (s_timeout) begin tmo_cnt++; tmo_cyc = cyc; end
      if (s_start) begin start_cnt++; start_cyc = cyc; end
      if (push_window && s_ready) bad_ready++;
      if (s_wr) begin
         wlog.push_back(s_wdata);
         if (bus.i_tx_full) wr_full_cnt++;
      end
      if (wlog.size() >= 4) push_window = 1'b0;
      @(posedge clk);
      #1;
      if (s_rd && rxq.size() != 0) void'(rxq.pop_front());
      drive_rx();
   endtask

   task automatic wait_valid(input int bound, output logic seen);
      seen = 1'b0;
      for (int i = 0; i < bound && !seen; i++) begin
         tick();
         if (s_valid) seen = 1'b1;
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic        seen;
      logic [31:0] held;
      int          bad;

      cyc = 0; pop_cnt = 0; tmo_cnt = 0; start_cnt = 0; wr_full_cnt = 0;
      hold_pop_cnt = 0; bad_ready = 0; push_window = 1'b0;
      first_pop_cyc = 0; last_pop_cyc = 0; tmo_cyc = 0; start_cyc = 0;
      bus.i_tx_full = 1'b0;  bus.i_tx_empty = 1'b1;  bus.i_tx_done = 1'b0;
      bus.i_rx_ready = 1'b1; bus.i_tx_word = '0;     bus.i_tx_valid = 1'b0;
      timeout = '0;
      drive_rx();
      rst_n = 1'b1;
      #1 rst_n = 1'b0;
      #1;
      check("reset_rd",       bus.o_rd,       0);
      check("reset_wr",       bus.o_wr,       0);
      check("reset_start",    bus.o_tx_start, 0);
      check("reset_tx_ready", bus.o_tx_ready, 1);
      check("reset_rx_valid", bus.o_rx_valid, 0);
      check("reset_rx_word",  bus.o_rx_word,  0);
      check("reset_timeout",  rx_timeout,     0);
      check("reset_busy",     busy,           0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;

      // RX: one word, client always ready
      pop_cnt = 0;
      load_rx(32'h12345678, 4);
      wait_valid(20, seen);
      check("rx1_valid_seen", seen, 1);
      check("rx1_pops", pop_cnt, 4);
      check("rx1_pops_back_to_back", last_pop_cyc - first_pop_cyc, 3);
      check("rx1_valid_latency", cyc - last_pop_cyc, 1);
      check("rx1_word", s_word, 32'h12345678);
      tick();
      check("rx1_valid_drop", s_valid, 0);

      // RX: two words queued, client stalls 20 cycles
      bus.i_rx_ready = 1'b0;
      pop_cnt = 0; hold_pop_cnt = 0;
      load_rx(32'h04030201, 4);
      load_rx(32'h08070605, 4);
      wait_valid(20, seen);
      check("rx2_valid_seen", seen, 1);
      check("rx2_word_a", s_word, 32'h04030201);
      held = s_word; bad = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (!(s_valid && s_word == held)) bad++;
      end
      check("rx2_hold_stable", bad, 0);
      check("rx2_pops_while_held", pop_cnt, 4);
      bus.i_rx_ready = 1'b1;
      tick();
      tick();
      check("rx2_valid_drop", s_valid, 0);
      wait_valid(20, seen);
      check("rx2_valid2_seen", seen, 1);
      check("rx2_word_b", s_word, 32'h08070605);
      check("rx2_pops_total", pop_cnt, 8);
      check("rx2_no_pop_in_hold", hold_pop_cnt, 0);
      tick();

      // RX timeout = 10 after two bytes; the pulse rises on the 10th edge after
      // the popping edge, i.e. 11 falling-edge samples after the pop sample.
      timeout = 16'd10;
      pop_cnt = 0; tmo_cnt = 0; seen = 1'b0;
      load_rx(32'h0000BBAA, 2);
      for (int i = 0; i < 40 && !seen; i++) begin
         tick();
         if (s_timeout) seen = 1'b1;
      end
      check("tmo_seen", seen, 1);
      check("tmo_pops", pop_cnt, 2);
      check("tmo_delay", tmo_cyc - last_pop_cyc, 11);
      repeat (5) tick();
      check("tmo_single_pulse", tmo_cnt, 1);
      load_rx(32'h44332211, 4);
      wait_valid(20, seen);
      check("tmo_fresh_seen", seen, 1);
      check("tmo_fresh_word", s_word, 32'h44332211);
      tick();

      // Pop in the same cycle as expiry (timeout = 3) keeps the byte
      timeout = 16'd3;
      tmo_cnt = 0;
      load_rx(32'h000000E1, 1);
      repeat (3) tick();
      load_rx(32'h00E4E3E2, 3);
      wait_valid(20, seen);
      check("tmo_race_seen", seen, 1);
      check("tmo_race_word", s_word, 32'hE4E3E2E1);
      check("tmo_race_no_pulse", tmo_cnt, 0);
      tick();

      // Timeout disabled: a long gap keeps the partial word
      timeout = 16'd0;
      tmo_cnt = 0;
      load_rx(32'h00006655, 2);
      repeat (50) tick();
      check("tmo_off_no_pulse", tmo_cnt, 0);
      load_rx(32'h00008877, 2);
      wait_valid(20, seen);
      check("tmo_off_word", s_word, 32'h88776655);
      tick();

      // TX word split with the FIFO full during the second byte
      wlog.delete(); wr_full_cnt = 0; bad_ready = 0;
      bus.i_tx_word  = 32'hDEADBEEF;
      bus.i_tx_valid = 1'b1;
      tick();
      check("tx_ready_idle", s_ready, 1);
      bus.i_tx_valid = 1'b0;
      push_window = 1'b1;
      tick();
      bus.i_tx_full = 1'b1;
      repeat (5) tick();
      check("tx_stall_pushes", wlog.size(), 1);
      bus.i_tx_full = 1'b0;
      for (int i = 0; i < 20 && wlog.size() < 4; i++) tick();
      check("tx_push_count", wlog.size(), 4);
      check("tx_lane0", (wlog.size() > 0) ? wlog[0] : 8'h00, 8'hEF);
      check("tx_lane1", (wlog.size() > 1) ? wlog[1] : 8'h00, 8'hBE);
      check("tx_lane2", (wlog.size() > 2) ? wlog[2] : 8'h00, 8'hAD);
      check("tx_lane3", (wlog.size() > 3) ? wlog[3] : 8'h00, 8'hDE);
      check("tx_no_wr_when_full", wr_full_cnt, 0);
      check("tx_ready_low_in_push", bad_ready, 0);
      tick();
      check("tx_ready_back", s_ready, 1);

      // Start sequencer with a slow UART
      start_cnt = 0;
      bus.i_tx_empty = 1'b0;
      tick();
      check("st_first_start", start_cnt, 1);
      repeat (100) tick();
      check("st_single_start", start_cnt, 1);
      check("st_busy", s_busy, 1);
      bus.i_tx_done = 1'b1;
      tick();
      bad = cyc;
      bus.i_tx_done = 1'b0;
      tick();
      check("st_restart", start_cnt, 2);
      check("st_restart_delay", start_cyc - bad, 1);
      bus.i_tx_empty = 1'b1;
      bus.i_tx_done  = 1'b1;
      tick();
      bus.i_tx_done  = 1'b0;
      repeat (3) tick();
      bus.i_tx_done  = 1'b1;
      tick();
      bus.i_tx_done  = 1'b0;
      repeat (3) tick();
      check("st_spurious_done", start_cnt, 2);
      bus.i_tx_empty = 1'b0;
      tick();
      check("st_start_after_idle", start_cnt, 3);

      // Reset in the middle of both words
      pop_cnt = 0;
      load_rx(32'h0000A2A1, 2);
      repeat (3) tick();
      check("rst_pre_rx_pops", pop_cnt, 2);
      bus.i_tx_full  = 1'b1;
      bus.i_tx_word  = 32'hCAFEF00D;
      bus.i_tx_valid = 1'b1;
      tick();
      bus.i_tx_valid = 1'b0;
      tick();
      check("rst_pre_tx_push", s_ready, 0);
      load_rx(32'hC4C3C2C1, 4);
      #2 rst_n = 1'b0;
      #1;
      check("rst_async_rd",       bus.o_rd,       0);
      check("rst_async_wr",       bus.o_wr,       0);
      check("rst_async_start",    bus.o_tx_start, 0);
      check("rst_async_tx_ready", bus.o_tx_ready, 1);
      check("rst_async_rx_valid", bus.o_rx_valid, 0);
      check("rst_async_rx_word",  bus.o_rx_word,  0);
      check("rst_async_timeout",  rx_timeout,     0);
      check("rst_async_busy",     busy,           1);
      repeat (2) tick();
      rst_n = 1'b1;
      bus.i_tx_full  = 1'b0;
      bus.i_tx_empty = 1'b1;
      pop_cnt = 0;
      wlog.delete();
      wait_valid(20, seen);
      check("rst_post_seen", seen, 1);
      check("rst_post_word", s_word, 32'hC4C3C2C1);
      check("rst_post_pops", pop_cnt, 4);
      check("rst_post_no_push", wlog.size(), 0);
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
